// File: rtl/udp_test_pkg.sv
// Shared constants for the UDP link test: payload length, the fixed test
// payload (MSB = first byte on the wire), receiver FSM encoding and a
// saturating-increment helper used by the statistics counters.
package udp_test_pkg;

    localparam int UDP_TEST_LEN = 20;

    localparam logic [8*UDP_TEST_LEN-1:0] UDP_TEST_PATTERN = "www.meyesemi.com   \n";

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_REPORT = 2'd2
    } rx_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_test_pattern_rom.sv
// Combinational lookup of the test payload: byte index -> expected byte.
// Indices past the end of the payload read as 8'h00. Shared with the
// transmitter so both ends agree on the payload.
module udp_test_pattern_rom
    import udp_test_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] data
);

    // Constant-index select per entry keeps the lookup a plain mux.
    always_comb begin
        data = 8'h00;
        for (int i = 0; i < UDP_TEST_LEN; i++) begin
            if (idx == 5'(i))
                data = UDP_TEST_PATTERN[8*(UDP_TEST_LEN-1-i) +: 8];
        end
    end

endmodule

// File: rtl/udp_rx_checker.sv
// Receive-side checker for the periodic UDP test packet. Counts and compares
// each payload byte against the fixed test pattern, reports per-packet
// status flags and keeps saturating statistics.
// Optional: define UDP_RX_CHK_TIMEOUT_EN to build the idle link timeout;
// otherwise link_timeout is tied low.
module udp_rx_checker
    import udp_test_pkg::*;
#(
    parameter int          EXP_LEN        = 20,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        udp_rec_data_valid,
    input  logic [7:0]  udp_rec_rdata,
    input  logic [15:0] udp_rec_data_length,
    input  logic        clear_stats,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        err_len,
    output logic        err_short,
    output logic        err_long,
    output logic        err_data,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
    output logic [15:0] byte_err_cnt,
    output logic [15:0] last_len,
    output logic        link_timeout
);

    localparam logic [15:0] EXP_LEN16 = 16'(EXP_LEN);

    rx_state_e   state_q, state_d;
    logic        start, take, report;
    logic [15:0] cnt, len_q, byte_idx;
    logic        mis_q, cmp_vld_q, byte_mis;
    logic [7:0]  data_q, pat_byte;
    logic [4:0]  idx_q;

    udp_test_pattern_rom u_rom (
        .idx  (idx_q),
        .data (pat_byte)
    );

    // A byte taken outside RECV always opens a new packet at index 0.
    assign byte_idx = (state_q == ST_RECV) ? cnt : 16'd0;
    // Compare is done on the registered byte, so it lands one cycle late.
    assign byte_mis = cmp_vld_q && (data_q != pat_byte);

    // State register.
    always_ff @(posedge rgmii_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-cycle strobes; REPORT may also open the next packet.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        take    = 1'b0;
        report  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (udp_rec_data_valid) begin
                    start   = 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (udp_rec_data_valid) take = 1'b1;
                else                    state_d = ST_REPORT;
            end
            ST_REPORT: begin
                report = 1'b1;
                if (udp_rec_data_valid) begin
                    start   = 1'b1;
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte counter, latched length, registered compare stage, sticky mismatch.
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            cnt       <= '0;
            len_q     <= '0;
            mis_q     <= 1'b0;
            cmp_vld_q <= 1'b0;
            data_q    <= '0;
            idx_q     <= '0;
        end else begin
            cmp_vld_q <= (start || take) && (byte_idx < EXP_LEN16);
            data_q    <= udp_rec_rdata;
            idx_q     <= byte_idx[4:0];
            if (start) begin
                len_q <= udp_rec_data_length;
                cnt   <= 16'd1;
                mis_q <= 1'b0;
            end else begin
                if (take)     cnt   <= sat_inc(cnt);
                if (byte_mis) mis_q <= 1'b1;
            end
        end
    end

    // Per-packet status, registered in REPORT and held until the next one.
    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            err_len   <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_data  <= 1'b0;
            last_len  <= '0;
        end else begin
            pkt_done <= report;
            if (report) begin
                err_len   <= (len_q != EXP_LEN16);
                err_short <= (cnt < len_q);
                err_long  <= (cnt > len_q);
                err_data  <= mis_q;
                pkt_ok    <= (len_q == EXP_LEN16) && (cnt == len_q) && !mis_q;
                last_len  <= cnt;
            end
        end
    end

    // Saturating statistics; clear_stats overrides any same-cycle increment.
    always_ff @(posedge rgmii_clk) begin
        if (rst || clear_stats) begin
            good_cnt     <= '0;
            bad_cnt      <= '0;
            byte_err_cnt <= '0;
        end else begin
            if (report) begin
                if ((len_q == EXP_LEN16) && (cnt == len_q) && !mis_q)
                    good_cnt <= sat_inc(good_cnt);
                else
                    bad_cnt  <= sat_inc(bad_cnt);
            end
            if (byte_mis) byte_err_cnt <= sat_inc(byte_err_cnt);
        end
    end

`ifdef UDP_RX_CHK_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // Idle counter parks at the limit so link_timeout stays high until traffic.
    always_ff @(posedge rgmii_clk) begin
        if (rst || pkt_done)                 idle_cnt <= '0;
        else if (idle_cnt != TIMEOUT_CYCLES) idle_cnt <= idle_cnt + 32'd1;
    end

    assign link_timeout = (idle_cnt == TIMEOUT_CYCLES);
`else
    // Timeout not built; parameter still referenced so both builds share one interface.
    assign link_timeout = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

endmodule

// File: tb/tb_udp_rx_checker.sv
// Self-checking bench for udp_rx_checker: expected packet reports are pushed
// to a queue as packets are driven and popped when pkt_done is seen.
// With UDP_RX_CHK_TIMEOUT_EN defined the timeout is checked at 100 cycles.
module tb_udp_rx_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  rdata;
    logic [15:0] length;
    logic        clear;
    logic        pkt_done, pkt_ok, err_len, err_short, err_long, err_data;
    logic [15:0] good_cnt, bad_cnt, byte_err_cnt, last_len;
    logic        link_timeout;

    typedef struct {
        int          cyc;
        logic        ok, el, es, elg, ed;
        logic [15:0] last_len, good, bad, berr;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          r0;
    logic [7:0]  pbuf[64];
    logic [15:0] good_m, bad_m, berr_m;
    string       PAT = "www.meyesemi.com   \n";

    udp_rx_checker #(.EXP_LEN(20), .TIMEOUT_CYCLES(32'd100)) dut (
        .rgmii_clk           (clk),
        .rst                 (rst),
        .udp_rec_data_valid  (valid),
        .udp_rec_rdata       (rdata),
        .udp_rec_data_length (length),
        .clear_stats         (clear),
        .pkt_done            (pkt_done),
        .pkt_ok              (pkt_ok),
        .err_len             (err_len),
        .err_short           (err_short),
        .err_long            (err_long),
        .err_data            (err_data),
        .good_cnt            (good_cnt),
        .bad_cnt             (bad_cnt),
        .byte_err_cnt        (byte_err_cnt),
        .last_len            (last_len),
        .link_timeout        (link_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic fill_pattern(input int n);
        for (int i = 0; i < n; i++)
            pbuf[i] = (i < 20) ? PAT[i] : 8'(8'hA5 + i);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Drive pbuf[0..n-1] back to back, then one valid-low cycle; optional
    // clear_stats lined up with this packet's REPORT cycle.
    task automatic send_pkt(input int n, input logic [15:0] len, input bit clr);
        exp_t e;
        int   mism = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid  = 1'b1;
            rdata  = pbuf[i];
            length = len;
            if (i < 20 && pbuf[i] != PAT[i]) mism++;
        end
        e.cyc = cyc + 3;
        @(negedge clk);
        valid = 1'b0;
        rdata = 8'h00;
        e.el       = (len != 16'd20);
        e.es       = (n < int'(len));
        e.elg      = (n > int'(len));
        e.ed       = (mism != 0);
        e.ok       = !(e.el || e.es || e.elg || e.ed);
        e.last_len = 16'(n);
        for (int i = 0; i < mism; i++) berr_m = sat16(berr_m);
        if (clr) begin
            good_m = 0; bad_m = 0; berr_m = 0;
        end else if (e.ok) good_m = sat16(good_m);
        else               bad_m  = sat16(bad_m);
        e.good = good_m;
        e.bad  = bad_m;
        e.berr = berr_m;
        sb.push_back(e);
        if (clr) begin
            @(negedge clk); clear = 1'b1;
            @(negedge clk); clear = 1'b0;
        end
    endtask

    // Scoreboard side: every pkt_done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (pkt_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cyc",  cyc,          e.cyc);
                chk("pkt_ok",    pkt_ok,       e.ok);
                chk("err_len",   err_len,      e.el);
                chk("err_short", err_short,    e.es);
                chk("err_long",  err_long,     e.elg);
                chk("err_data",  err_data,     e.ed);
                chk("last_len",  last_len,     e.last_len);
                chk("good_cnt",  good_cnt,     e.good);
                chk("bad_cnt",   bad_cnt,      e.bad);
                chk("byte_err",  byte_err_cnt, e.berr);
            end
        end
    end

    initial begin
        rst = 1'b1; valid = 1'b0; rdata = 8'h00; length = 16'd0; clear = 1'b0;
        good_m = 0; bad_m = 0; berr_m = 0;
        idle(3);
        chk("rst_done",  pkt_done,     0);
        chk("rst_ok",    pkt_ok,       0);
        chk("rst_flags", {err_len, err_short, err_long, err_data}, 0);
        chk("rst_cnts",  {good_cnt, bad_cnt}, 0);
        chk("rst_berr",  byte_err_cnt, 0);
        chk("rst_len",   last_len,     0);
        chk("rst_to",    link_timeout, 0);
        rst = 1'b0;
        r0  = cyc;

`ifdef UDP_RX_CHK_TIMEOUT_EN
        while (cyc < r0 + 99) @(negedge clk);
        chk("to_before", link_timeout, 0);
        @(negedge clk);
        chk("to_rise", link_timeout, 1);
`else
        idle(150);
        chk("to_off", link_timeout, 0);
`endif

        // Clean packet
        fill_pattern(20);
        send_pkt(20, 16'd20, 1'b0);
        idle(4);
        chk("to_after_done", link_timeout, 0);

        // Byte 5 corrupted
        fill_pattern(20);
        pbuf[5] = 8'h00;
        send_pkt(20, 16'd20, 1'b0);
        idle(3);

        // Truncated after 12 bytes
        fill_pattern(20);
        send_pkt(12, 16'd20, 1'b0);
        idle(3);

        // Length field 16, 20 good bytes
        fill_pattern(20);
        send_pkt(20, 16'd16, 1'b0);
        idle(3);

        // Two packets, one-cycle gap, clear with the second REPORT
        fill_pattern(20);
        send_pkt(20, 16'd20, 1'b0);
        send_pkt(20, 16'd20, 1'b1);
        idle(3);
        chk("good_after_clr", good_cnt, 0);

        // Length 0: every byte is excess
        fill_pattern(3);
        send_pkt(3, 16'd0, 1'b0);
        idle(3);

        // Bytes past the pattern are not compared
        fill_pattern(22);
        send_pkt(22, 16'd22, 1'b0);
        idle(3);

        // Reset mid-packet: tail is a new packet from index 0
        fill_pattern(20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid = 1'b1; rdata = pbuf[i]; length = 16'd20;
        end
        @(negedge clk);
        valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        good_m = 0; bad_m = 0; berr_m = 0;
        chk("midrst_good", good_cnt, 0);
        chk("midrst_len",  last_len, 0);
        for (int i = 0; i < 15; i++) pbuf[i] = PAT[i+5];
        send_pkt(15, 16'd20, 1'b0);
        idle(10);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
